// File: rtl/cdru_return.sv
// Read-return unit: tracks issued bank reads through the fixed memory latency and
// steers returning data into per-requester (i, d, c) first-word-fall-through FIFOs.
module cdru_return #(
  parameter int WORDWIDTH = 64,
  parameter int RDLAT     = 2,
  parameter int FIFODEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 m_en,
  input  logic [1:0]           m_muxcode,
  input  logic [WORDWIDTH-1:0] m_rdata,
  output logic                 i_rvalid,
  output logic [WORDWIDTH-1:0] i_rdata,
  input  logic                 i_rready,
  output logic                 i_credit,
  output logic                 d_rvalid,
  output logic [WORDWIDTH-1:0] d_rdata,
  input  logic                 d_rready,
  output logic                 d_credit,
  output logic                 c_rvalid,
  output logic [WORDWIDTH-1:0] c_rdata,
  input  logic                 c_rready,
  output logic                 c_credit,
  output logic                 err
);

  localparam int NREQ = 3;
  localparam int CW   = $clog2(FIFODEPTH + 1);
  localparam int PW   = (FIFODEPTH > 1) ? $clog2(FIFODEPTH) : 1;
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(FIFODEPTH);
  localparam logic [PW-1:0] LAST_P  = PW'(FIFODEPTH - 1);

  typedef logic [CW-1:0] cnt_t;

  logic [RDLAT-1:0]     tag_v;
  logic [1:0]           tag_c    [RDLAT];
  cnt_t                 inflight [NREQ];
  cnt_t                 count    [NREQ];
  logic [PW-1:0]        rd_ptr   [NREQ];
  logic [PW-1:0]        wr_ptr   [NREQ];
  logic [WORDWIDTH-1:0] mem      [NREQ][FIFODEPTH];
  logic [WORDWIDTH-1:0] head     [NREQ];
  logic [NREQ-1:0]      credit, rvalid, rready, issue, push, pop;
  logic                 err_q;

  assign rready = {c_rready, d_rready, i_rready};

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    credit = '0;
    rvalid = '0;
    issue  = '0;
    push   = '0;
    pop    = '0;
    for (int r = 0; r < NREQ; r++) begin
      head[r] = '0;
    end
    for (int r = 0; r < NREQ; r++) begin
      // Credit comes from registered state only; a same-cycle pop never raises it.
      credit[r] = ({1'b0, inflight[r]} + {1'b0, count[r]}) < DEPTH_W;
      rvalid[r] = count[r] != '0;
      issue[r]  = m_en && (m_muxcode == 2'(r)) && credit[r];
      push[r]   = tag_v[RDLAT-1] && (tag_c[RDLAT-1] == 2'(r));
      pop[r]    = rvalid[r] && rready[r];
      if (rvalid[r]) head[r] = mem[r][rd_ptr[r]];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      for (int s = 0; s < RDLAT; s++) tag_c[s] <= '0;
    end else begin
      // Illegal code or a read without credit never enters the line, so its data is dropped.
      tag_v[0] <= |issue;
      tag_c[0] <= m_muxcode;
      for (int s = 1; s < RDLAT; s++) begin
        tag_v[s] <= tag_v[s-1];
        tag_c[s] <= tag_c[s-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
      for (int r = 0; r < NREQ; r++) begin
        inflight[r] <= '0;
        count[r]    <= '0;
        rd_ptr[r]   <= '0;
        wr_ptr[r]   <= '0;
      end
    end else begin
      err_q <= err_q | (m_en & ~(|issue));
      for (int r = 0; r < NREQ; r++) begin
        inflight[r] <= inflight[r] + cnt_t'(issue[r]) - cnt_t'(push[r]);
        count[r]    <= count[r] + cnt_t'(push[r]) - cnt_t'(pop[r]);
        if (push[r]) wr_ptr[r] <= (wr_ptr[r] == LAST_P) ? '0 : wr_ptr[r] + 1'b1;
        if (pop[r])  rd_ptr[r] <= (rd_ptr[r] == LAST_P) ? '0 : rd_ptr[r] + 1'b1;
      end
    end
  end

  // NOTE: FIFO storage is not reset; occupancy counters alone decide what is visible.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NREQ; r++) begin
      if (push[r]) mem[r][wr_ptr[r]] <= m_rdata;
    end
  end

  assign i_rvalid = rvalid[0];
  assign d_rvalid = rvalid[1];
  assign c_rvalid = rvalid[2];
  assign i_rdata  = head[0];
  assign d_rdata  = head[1];
  assign c_rdata  = head[2];
  assign i_credit = credit[0];
  assign d_credit = credit[1];
  assign c_credit = credit[2];
  assign err      = err_q;

endmodule

// File: tb/tb_cdru_return.sv
// Directed self-checking bench for cdru_return (RDLAT=2, FIFODEPTH=2, WORDWIDTH=64).
module tb_cdru_return;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_en;
  logic [1:0]  m_muxcode;
  logic [63:0] m_rdata;
  logic        i_rvalid, d_rvalid, c_rvalid;
  logic [63:0] i_rdata, d_rdata, c_rdata;
  logic        i_rready, d_rready, c_rready;
  logic        i_credit, d_credit, c_credit;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  cdru_return #(.WORDWIDTH(64), .RDLAT(2), .FIFODEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_en(m_en), .m_muxcode(m_muxcode), .m_rdata(m_rdata),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_rready(i_rready), .i_credit(i_credit),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_rready(d_rready), .d_credit(d_credit),
    .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_rready(c_rready), .c_credit(c_credit),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_en = 1'b0; m_muxcode = 2'd0; m_rdata = '0;
    i_rready = 1'b0; d_rready = 1'b0; c_rready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check("rst_flags", {i_rvalid, d_rvalid, c_rvalid, i_credit, d_credit, c_credit, err}, 64'b0001110);
    check("rst_rdata", i_rdata | d_rdata | c_rdata, 64'h0);
  endtask

  logic [63:0] got_i[$], got_d[$], got_c[$];
  logic        seen;

  initial begin
    // Test 1: single d read, RDLAT=2
    do_reset();
    m_en = 1'b1; m_muxcode = 2'd1; d_rready = 1'b1;
    tick();                                  // E0
    m_en = 1'b0;
    tick();                                  // E1
    check("t1_early_valid", d_rvalid, 1'b0);
    m_rdata = 64'hAB;
    tick();                                  // E2
    m_rdata = 64'h0;
    check("t1_d_valid", {i_rvalid, d_rvalid, c_rvalid}, 3'b010);
    check("t1_d_rdata", d_rdata, 64'hAB);
    check("t1_d_credit", d_credit, 1'b1);
    tick();                                  // E3 pops
    check("t1_d_gone", {i_rvalid, d_rvalid, c_rvalid}, 3'b000);
    check("t1_err", err, 1'b0);

    // Test 2: credit exhaustion on i, third read dropped
    do_reset();
    m_en = 1'b1; m_muxcode = 2'd0;
    tick();                                  // E0
    check("t2_credit_after_1", i_credit, 1'b1);
    tick();                                  // E1
    check("t2_credit_after_2", i_credit, 1'b0);
    m_rdata = 64'h1111;
    tick();                                  // E2: third issue rejected, first word pushed
    check("t2_err", err, 1'b1);
    m_en = 1'b0; m_rdata = 64'h2222;
    tick();                                  // E3
    m_rdata = 64'h3333;
    tick();                                  // E4: nothing should be pushed
    check("t2_head0", i_rdata, 64'h1111);
    check("t2_credit_full", i_credit, 1'b0);
    i_rready = 1'b1;
    tick();                                  // E5
    check("t2_head1", {63'h0, i_rvalid} << 32 | i_rdata, 64'h1_0000_2222);
    tick();                                  // E6
    check("t2_empty", i_rvalid, 1'b0);
    check("t2_credit_back", i_credit, 1'b1);

    // Test 3: round-robin i,d,c for 9 cycles, all consumers ready
    do_reset();
    i_rready = 1'b1; d_rready = 1'b1; c_rready = 1'b1;
    got_i.delete(); got_d.delete(); got_c.delete();
    for (int k = 0; k < 14; k++) begin
      m_en      = (k < 9);
      m_muxcode = 2'(k % 3);
      m_rdata   = (k >= 2 && k < 11) ? 64'h10 + 64'(k - 2) : 64'hDEAD;
      tick();
      if (i_rvalid) got_i.push_back(i_rdata);
      if (d_rvalid) got_d.push_back(d_rdata);
      if (c_rvalid) got_c.push_back(c_rdata);
    end
    m_en = 1'b0;
    check("t3_i_count", 64'(got_i.size()), 64'd3);
    check("t3_d_count", 64'(got_d.size()), 64'd3);
    check("t3_c_count", 64'(got_c.size()), 64'd3);
    for (int j = 0; j < 3; j++) begin
      check("t3_i_word", (j < got_i.size()) ? got_i[j] : 64'hX, 64'h10 + 64'(3 * j));
      check("t3_d_word", (j < got_d.size()) ? got_d[j] : 64'hX, 64'h11 + 64'(3 * j));
      check("t3_c_word", (j < got_c.size()) ? got_c[j] : 64'hX, 64'h12 + 64'(3 * j));
    end
    check("t3_err", err, 1'b0);

    // Test 4: illegal code 3
    do_reset();
    i_rready = 1'b1; d_rready = 1'b1; c_rready = 1'b1;
    m_en = 1'b1; m_muxcode = 2'd3;
    tick();
    m_en = 1'b0; m_rdata = 64'hBAD;
    check("t4_err", err, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      seen = seen | i_rvalid | d_rvalid | c_rvalid;
    end
    check("t4_no_valid", seen, 1'b0);
    check("t4_credits", {i_credit, d_credit, c_credit}, 3'b111);

    // Test 5: reset with two c reads in flight
    do_reset();
    c_rready = 1'b1;
    m_en = 1'b1; m_muxcode = 2'd2;
    tick();                                  // E0
    tick();                                  // E1
    m_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", {i_rvalid, d_rvalid, c_rvalid}, 3'b000);
    check("t5_rst_credit", {i_credit, d_credit, c_credit}, 3'b111);
    m_rdata = 64'h55;
    tick();                                  // E2 while in reset
    rst_n = 1'b1;
    m_rdata = 64'h66;
    tick();                                  // E3
    check("t5_no_deliver_e3", c_rvalid, 1'b0);
    tick();
    check("t5_no_deliver_e4", c_rvalid, 1'b0);

    // Test 6: full c FIFO, one pop, credit returns next cycle, reissue
    do_reset();
    m_en = 1'b1; m_muxcode = 2'd2;
    tick();                                  // E0
    tick();                                  // E1
    m_en = 1'b0; m_rdata = 64'hC0;
    tick();                                  // E2
    m_rdata = 64'hC1;
    tick();                                  // E3
    check("t6_full_credit", c_credit, 1'b0);
    c_rready = 1'b1;
    #1;
    check("t6_credit_pop_cycle", c_credit, 1'b0);
    check("t6_head_c0", c_rdata, 64'hC0);
    tick();                                  // E4 pops C0
    c_rready = 1'b0;
    check("t6_credit_next", c_credit, 1'b1);
    check("t6_head_c1", c_rdata, 64'hC1);
    m_en = 1'b1; m_muxcode = 2'd2;
    tick();                                  // E5 issue
    m_en = 1'b0;
    tick();                                  // E6
    m_rdata = 64'hC2;
    tick();                                  // E7 push C2
    check("t6_err", err, 1'b0);
    c_rready = 1'b1;
    tick();
    check("t6_head_c2", c_rdata, 64'hC2);
    tick();
    check("t6_drained", c_rvalid, 1'b0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
